conv_window_sequencer: RTL
==========================

Name: conv_window_sequencer

Overview:
- Upstream feeder for the 4-to-1 tap mux in the convolution datapath.
- Accepts a pixel stream over a valid/ready handshake and holds a 4-deep sliding window of the most recent samples.
- After each new sample, once the window is full, it sweeps the tap select from 0 to 3 over four cycles. The mux therefore presents the taps serially to the downstream multiply-accumulate.
- Outputs i0..i3, s1 and s0 connect directly to the mux inputs of the same names; for WIDTH>1 the mux is bit-sliced.

Parameters:
WIDTH, 1, bits per sample; window registers and i0..i3 are WIDTH wide.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous window flush
in_valid  input  1  upstream sample valid
in_data  input  WIDTH  upstream sample
in_ready  output  1  block can accept a sample this cycle
tap_ready  input  1  downstream accepts the current tap
i0  output  WIDTH  window tap 0 (oldest sample)
i1  output  WIDTH  window tap 1
i2  output  WIDTH  window tap 2
i3  output  WIDTH  window tap 3 (newest sample)
s1  output  1  tap select MSB to mux
s0  output  1  tap select LSB to mux
tap_valid  output  1  the current select/tap is valid
tap_last  output  1  the current tap is tap 3 of the sweep
window_full  output  1  the window holds 4 valid samples

Behaviour:
- Reset (rst_n=0, asynchronous): the following all reset to 0: i0..i3, s1, s0, tap_valid, tap_last, window_full, fill count. State resets to FILL. in_ready=1 immediately after reset deasserts.
- All outputs are registered except in_ready, which is decoded from the state: in_ready=1 in FILL and WAIT, 0 in SWEEP.
- Accept means in_valid&&in_ready at a rising edge. On accept the window shifts: i0<=i1, i1<=i2, i2<=i3, i3<=in_data.
- States:
  - FILL: fill count 0..3. Each accept increments the count. The accept that makes the count 4 sets window_full=1 and moves to SWEEP.
  - WAIT: window full, waiting for a sample. An accept moves to SWEEP.
  - SWEEP: tap_valid=1, {s1,s0}=tap index. The index advances only on a cycle where tap_ready=1. tap_last=1 when the index is 3. Tap 3 with tap_ready=1 returns the state to WAIT, tap_valid goes to 0 and {s1,s0} goes to 0.
- Latency: the accept at edge N gives tap_valid=1 with {s1,s0}=00 in the cycle after edge N. A full sweep takes 4 cycles with tap_ready held high. The minimum sample period is 5 cycles (1 accept + 4 taps).
- i0..i3 are stable throughout a sweep, because no accept can occur while in_ready=0.
- tap_ready=0 in SWEEP holds s1, s0, tap_valid and tap_last unchanged. tap_ready is ignored outside SWEEP.
- clear=1 at an edge:
  - fill count<=0, window_full<=0, tap_valid<=0, tap_last<=0, {s1,s0}<=00, state<=FILL.
  - i0..i3 are not zeroed.
  - clear has priority over a simultaneous accept: the sample is dropped and not shifted in.
  - clear in the middle of a sweep aborts the sweep immediately.
- rst_n asserted mid-sweep: all outputs go to reset values asynchronously; no partial tap is emitted after release.
- in_valid=1 while in_ready=0: the sample is neither shifted nor counted; upstream must hold it.

Test Plan:
- Reset then fill (WIDTH=8): accept 0x11, 0x22, 0x33, 0x44 on consecutive cycles, tap_ready=1 -> window_full=1 one cycle after the 4th accept. Over the next 4 cycles {s1,s0}=00,01,10,11 with i0..i3=11,22,33,44, tap_valid=1, tap_last=1 only on the 4th. in_ready=0 for those 4 cycles, then 1.
- Slide: after that sweep, accept 0x55 -> i0..i3=22,33,44,55 and a new 4-tap sweep starts the next cycle. 10 samples streamed with in_valid held high -> exactly 7 sweeps, with accepts spaced 5 cycles apart once full.
- Backpressure: during a sweep, drive tap_ready=0 for 3 cycles at index 01 -> {s1,s0}=01 and tap_valid=1 are held for 3 extra cycles. Sweep completes 3 cycles late, with no index skipped or repeated.
- Clear: assert clear together with in_valid in the middle of the sweep at index 10 -> next cycle tap_valid=0, window_full=0, in_ready=1, sample not shifted. 4 further accepts are needed before the next sweep.
- Async reset mid-sweep: drop rst_n between clock edges at index 10 -> all outputs are 0 before the next edge. After release, 3 accepts produce no tap_valid.
- Stall on input: in_valid=1 throughout a sweep -> i3 is unchanged until the WAIT cycle, and the held sample is accepted exactly once.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//
// Upstream feeder for the 4-to-1 tap mux in the convolution datapath.
// Samples arrive over a valid/ready handshake and are shifted into a
// 4-deep sliding window (i0 = oldest, i3 = newest). Once the window holds
// four samples, every newly accepted sample triggers a sweep of the tap
// select {s1,s0} from 0 to 3, so the mux presents the taps one at a time
// to the downstream multiply-accumulate.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous window flush (wins over a simultaneous accept)
//   in_valid     upstream sample valid
//   in_data      upstream sample, WIDTH bits
//   in_ready     block can accept a sample this cycle (low during a sweep)
//   tap_ready    downstream accepts the current tap
//   i0..i3       window taps to the mux, WIDTH bits each
//   s1, s0       tap select to the mux
//   tap_valid    current select/tap is valid
//   tap_last     current tap is tap 3 of the sweep
//   window_full  window holds 4 valid samples
module conv_window_sequencer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             tap_ready,
  output logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic             s1,
  output logic             s0,
  output logic             tap_valid,
  output logic             tap_last,
  output logic             window_full
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] fill_q;
  logic [1:0] fill_d;
  logic [1:0] sel_q;
  logic [1:0] sel_d;
  logic       full_d;
  logic       tap_valid_d;
  logic       tap_last_d;
  logic       shift;
  logic       accept;

  // Ready is decoded straight from the state so a sweep can never see its
  // window change underneath it.
  assign in_ready = (state_q != SWEEP);
  assign accept   = in_valid && in_ready;
  assign sel_q    = {s1, s0};

  // State and fill-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state and next-output decode. clear is checked first so that it
  // drops any sample offered in the same cycle and aborts a running sweep.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    sel_d       = sel_q;
    full_d      = window_full;
    tap_valid_d = tap_valid;
    tap_last_d  = tap_last;
    shift       = 1'b0;

    if (clear) begin
      state_d     = FILL;
      fill_d      = 2'd0;
      sel_d       = 2'd0;
      full_d      = 1'b0;
      tap_valid_d = 1'b0;
      tap_last_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            shift = 1'b1;
            if (fill_q == 2'd3) begin
              // Fourth sample: window is now full, start the first sweep.
              fill_d      = 2'd0;
              full_d      = 1'b1;
              state_d     = SWEEP;
              sel_d       = 2'd0;
              tap_valid_d = 1'b1;
              tap_last_d  = 1'b0;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end
        end

        WAIT: begin
          if (accept) begin
            shift       = 1'b1;
            state_d     = SWEEP;
            sel_d       = 2'd0;
            tap_valid_d = 1'b1;
            tap_last_d  = 1'b0;
          end
        end

        SWEEP: begin
          // The index only moves when the downstream takes the tap.
          if (tap_ready) begin
            if (sel_q == 2'd3) begin
              state_d     = WAIT;
              sel_d       = 2'd0;
              tap_valid_d = 1'b0;
              tap_last_d  = 1'b0;
            end else begin
              sel_d      = sel_q + 2'd1;
              tap_last_d = (sel_q == 2'd2);
            end
          end
        end

        default: begin
          state_d     = FILL;
          fill_d      = 2'd0;
          sel_d       = 2'd0;
          full_d      = 1'b0;
          tap_valid_d = 1'b0;
          tap_last_d  = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and the sliding window. The window is deliberately
  // not zeroed by clear; only reset wipes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i0          <= '0;
      i1          <= '0;
      i2          <= '0;
      i3          <= '0;
      s1          <= 1'b0;
      s0          <= 1'b0;
      tap_valid   <= 1'b0;
      tap_last    <= 1'b0;
      window_full <= 1'b0;
    end else begin
      s1          <= sel_d[1];
      s0          <= sel_d[0];
      tap_valid   <= tap_valid_d;
      tap_last    <= tap_last_d;
      window_full <= full_d;
      if (shift) begin
        i0 <= i1;
        i1 <= i2;
        i2 <= i3;
        i3 <= in_data;
      end
    end
  end

endmodule
